mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter PIPE_DEPTH, default 5, cycles from operand issue on mul_dataa/mul_datab to the matching product on mul_res, with mul_enable held high.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_a  input  NUM_REQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NUM_REQ*WIDTH  operand B, same slicing.
REQ-009 req_ready  output  NUM_REQ  one-hot grant, combinational from req_valid and the priority pointer.
REQ-010 resp_valid  output  NUM_REQ  one-hot product-return strobe, registered.
REQ-011 resp_data  output  2*WIDTH  product for the requester flagged in resp_valid, registered.
REQ-012 mul_enable  output  1  enable to the shared multiplier.
REQ-013 mul_dataa, mul_datab  output  WIDTH each  operands to the shared multiplier.
REQ-014 mul_res  input  2*WIDTH  product from the shared multiplier.
REQ-015 inflight  output  clog2(PIPE_DEPTH+1)  number of operations issued but not yet returned.
REQ-016 idle  output  1  high when inflight == 0 and req_valid == 0.

Function
REQ-017 Handshake: requester i's operation is accepted in a cycle where req_valid[i] and req_ready[i] are both high; at most one acceptance per cycle.
REQ-018 Arbitration: round-robin. Grant goes to the first index with req_valid set, searching ptr, ptr+1, ... mod NUM_REQ.
REQ-019 Pointer update: after accepting requester g, ptr becomes (g+1) mod NUM_REQ; ptr is unchanged when nothing is accepted.
REQ-020 req_ready is all-zero when req_valid is zero or reset is high.
REQ-021 mul_enable is high in every cycle where reset is low, so the multiplier pipeline advances every cycle at a fixed latency.
REQ-022 mul_dataa/mul_datab carry the granted requester's operands in the accept cycle and zero otherwise.
REQ-023 Tag pipeline: a PIPE_DEPTH-stage shift register of {valid, index}. Stage 0 is loaded with {accept, g} every cycle and advances unconditionally.
REQ-024 When the last tag stage is valid with index k, the design captures mul_res into resp_data and asserts resp_valid[k] on the next edge, so the total accept-to-resp_valid latency is PIPE_DEPTH+1 cycles.
REQ-025 resp_valid is high for exactly one cycle per accepted operation, and at most one bit is set per cycle.
REQ-026 Responses have no backpressure; requesters must sink resp_data in the resp_valid cycle.
REQ-027 Responses return in issue order, and every accepted operation returns exactly once.
REQ-028 Arithmetic: the product is an unsigned full-width 2*WIDTH result with no truncation; the block does not alter mul_res.
REQ-029 inflight increments on accept and decrements when a response is emitted. When both happen in the same cycle, it is unchanged.
REQ-030 Back-to-back operation: one accept per cycle is sustained indefinitely, and inflight saturates at PIPE_DEPTH by construction.
REQ-031 A requester holding req_valid continuously with others idle is granted every cycle.

Reset
REQ-032 While reset is high: ptr = 0, all tag stages invalid, inflight = 0, resp_valid = 0, resp_data = 0, mul_enable = 0, idle = 1 once req_valid is low.
REQ-033 Reset mid-operation discards all in-flight operations. No resp_valid for them may appear after reset deasserts.
REQ-034 The first cycle after reset deassertion accepts normally, with ptr = 0.

Verification
REQ-035 Single op: after reset, req_valid = 0001, a = 3, b = 5 for one cycle -> req_ready = 0001 that cycle; resp_valid = 0001 and resp_data = 15 exactly 6 cycles later; inflight is 1 during the wait, then 0.
REQ-036 Round-robin: req_valid = 1111 held for 8 cycles -> grants in order 0, 1, 2, 3, 0, 1, 2, 3; responses follow in the same order at +6 cycles.
REQ-037 Full width: a = b = 255 -> resp_data = 65025; a = 0, b = 200 -> resp_data = 0.
REQ-038 Pointer skip: ptr = 2 (after a grant to 1) and req_valid = 0011 -> grant to 0, then ptr = 1.
REQ-039 Reset mid-flight: issue 3 ops on consecutive cycles, then pulse reset in the 2nd cycle after the last issue -> no resp_valid ever; inflight = 0; next op returns normally.
REQ-040 Simultaneous accept and return: a continuous stream on requester 3 -> inflight is steady at 5, with resp_valid = 1000 every cycle from cycle 6 onward.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one pipelined multiplier
// among NUM_REQ requesters and routes each product back to its issuer.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   req_valid[NUM_REQ]      per-requester operation request
//   req_a, req_b            packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready[NUM_REQ]      one-hot grant (combinational)
//   resp_valid[NUM_REQ]     one-hot product-return strobe (registered)
//   resp_data[2*WIDTH]      product for the flagged requester (registered)
//   mul_enable              shared multiplier enable (high out of reset)
//   mul_dataa, mul_datab    operands to the shared multiplier
//   mul_res[2*WIDTH]        product from the shared multiplier, PIPE_DEPTH later
//   inflight                operations issued and not yet returned
//   idle                    nothing in flight and nothing requested
module mult_arbiter #(
    parameter int WIDTH      = 8,
    parameter int NUM_REQ    = 4,
    parameter int PIPE_DEPTH = 5,
    localparam int IDXW      = $clog2(NUM_REQ),
    localparam int CNTW      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [2*WIDTH-1:0]         resp_data,
    output logic                       mul_enable,
    output logic [WIDTH-1:0]           mul_dataa,
    output logic [WIDTH-1:0]           mul_datab,
    input  logic [2*WIDTH-1:0]         mul_res,
    output logic [CNTW-1:0]            inflight,
    output logic                       idle
);

    logic [IDXW-1:0]                  ptr;
    logic [IDXW-1:0]                  gnt_idx;
    logic                             accept;

    // Tag pipeline tracks which requester owns each multiplier stage.
    logic [PIPE_DEPTH-1:0]            vld_pipe;
    logic [PIPE_DEPTH-1:0][IDXW-1:0]  idx_pipe;
    logic                             ret;
    logic [IDXW-1:0]                  ret_idx;

    assign ret     = vld_pipe[PIPE_DEPTH-1];
    assign ret_idx = idx_pipe[PIPE_DEPTH-1];

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int cand;
        accept    = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        cand      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!accept && req_valid[cand]) begin
                accept  = 1'b1;
                gnt_idx = IDXW'(cand);
            end
        end
        if (reset) accept = 1'b0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    // Operands are zeroed when nothing is granted so the multiplier never
    // sees stale data from an idle requester.
    assign mul_enable = ~reset;
    assign mul_dataa  = accept ? req_a[gnt_idx*WIDTH +: WIDTH] : '0;
    assign mul_datab  = accept ? req_b[gnt_idx*WIDTH +: WIDTH] : '0;

    assign idle = (inflight == '0) && (req_valid == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            vld_pipe   <= '0;
            idx_pipe   <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            inflight   <= '0;
        end else begin
            if (accept)
                ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

            // Advances every cycle; the multiplier has the same fixed latency.
            vld_pipe[0] <= accept;
            idx_pipe[0] <= gnt_idx;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end

            resp_valid <= '0;
            if (ret) begin
                resp_valid[ret_idx] <= 1'b1;
                resp_data           <= mul_res;
            end

            case ({accept, ret})
                2'b10:   inflight <= inflight + CNTW'(1);
                2'b01:   inflight <= inflight - CNTW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int PD = 5;
    localparam int CW = $clog2(PD + 1);

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_a, req_b;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [2*W-1:0]    resp_data;
    logic              mul_enable;
    logic [W-1:0]      mul_dataa, mul_datab;
    logic [2*W-1:0]    mul_res;
    logic [CW-1:0]     inflight;
    logic              idle;

    mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_data(resp_data), .mul_enable(mul_enable), .mul_dataa(mul_dataa),
        .mul_datab(mul_datab), .mul_res(mul_res), .inflight(inflight), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: PD-stage pipeline advancing on mul_enable.
    logic [2*W-1:0] mstage [PD];
    always @(posedge clk) begin
        if (mul_enable) begin
            mstage[0] <= {{W{1'b0}}, mul_dataa} * {{W{1'b0}}, mul_datab};
            for (int s = 1; s < PD; s++) mstage[s] <= mstage[s-1];
        end
    end
    assign mul_res = mstage[PD-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           idx;
        logic [2*W-1:0] prod;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic push(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] pa, pb;
        pa = {{W{1'b0}}, a};
        pb = {{W{1'b0}}, b};
        e.idx  = idx;
        e.prod = pa * pb;
        e.cyc  = cyc + PD + 1;
        sb.push_back(e);
    endtask

    // Scoreboard pop: every due entry must appear exactly in its cycle,
    // and any other resp_valid is an error.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (mon_e.cyc != cyc || resp_valid !== oh(mon_e.idx) || resp_data !== mon_e.prod) begin
                n_fail++;
                $display("FAIL resp: got valid=%b data=%0d at cycle %0d, want valid=%b data=%0d at cycle %0d",
                         resp_valid, resp_data, cyc, oh(mon_e.idx), mon_e.prod, mon_e.cyc);
            end
        end else if (resp_valid !== '0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_resp: got valid=%b data=%0d at cycle %0d, want valid=0",
                     resp_valid, resp_data, cyc);
        end
    end

    // One cycle of stimulus: drive after the edge, return at the falling edge.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        @(posedge clk);
        #1;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() != 0 && b < 40) begin
            step('0, '0, '0);
            b++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        #1 req_valid = 4'b1111;
        @(negedge clk);
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        n_chk++; if (mul_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mul_enable: got %b want 0", mul_enable); end
        n_chk++; if (resp_valid !== '0 || resp_data !== '0) begin n_fail++; $display("FAIL rst_resp: got %b/%0d want 0/0", resp_valid, resp_data); end
        n_chk++; if (inflight !== '0) begin n_fail++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
        n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", idle); end
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", idle); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_single();
        logic [N*W-1:0] a, b;
        a = '0; b = '0;
        a[0 +: W] = 8'd3;
        b[0 +: W] = 8'd5;
        step(4'b0001, a, b);
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        n_chk++; if (mul_dataa !== 8'd3 || mul_datab !== 8'd5 || mul_enable !== 1'b1)
            begin n_fail++; $display("FAIL single_operands: got %0d,%0d en=%b want 3,5 en=1", mul_dataa, mul_datab, mul_enable); end
        push(0, 8'd3, 8'd5);
        for (int k = 1; k <= PD; k++) begin
            step('0, '0, '0);
            n_chk++; if (inflight !== CW'(1)) begin n_fail++; $display("FAIL single_inflight_wait: got %0d want 1 (k=%0d)", inflight, k); end
            if (k == 1) begin
                n_chk++; if (mul_dataa !== '0 || mul_datab !== '0) begin n_fail++; $display("FAIL single_idle_operands: got %0d,%0d want 0,0", mul_dataa, mul_datab); end
            end
        end
        step('0, '0, '0);
        n_chk++; if (inflight !== '0) begin n_fail++; $display("FAIL single_inflight_done: got %0d want 0", inflight); end
        drain();
    endtask

    task automatic test_round_robin();
        logic [N*W-1:0] a, b;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                a[i*W +: W] = W'(10 * k + i + 1);
                b[i*W +: W] = W'(7 + i + k);
            end
            step(4'b1111, a, b);
            n_chk++; if (req_ready !== oh(k % N)) begin n_fail++; $display("FAIL rr_grant: got %b want %b (k=%0d)", req_ready, oh(k % N), k); end
            push(k % N, a[(k % N)*W +: W], b[(k % N)*W +: W]);
        end
        drain();
    endtask

    task automatic test_full_width();
        logic [N*W-1:0] a, b;
        a = '0; b = '0;
        a[2*W +: W] = 8'd255;
        b[2*W +: W] = 8'd255;
        step(4'b0100, a, b);
        n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL fw_ready2: got %b want 0100", req_ready); end
        push(2, 8'd255, 8'd255);
        a = '0; b = '0;
        b[1*W +: W] = 8'd200;
        step(4'b0010, a, b);
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL fw_ready1: got %b want 0010", req_ready); end
        push(1, 8'd0, 8'd200);
        step('0, '0, '0);
        n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL fw_idle_busy: got %b want 0", idle); end
        drain();
    endtask

    task automatic test_ptr_skip();
        logic [N*W-1:0] a, b;
        logic [N-1:0]   v   [3] = '{4'b0010, 4'b0011, 4'b0011};
        int             g   [3] = '{1, 0, 1};
        for (int k = 0; k < 3; k++) begin
            a = N*W'($urandom);
            b = N*W'($urandom);
            step(v[k], a, b);
            n_chk++; if (req_ready !== oh(g[k])) begin n_fail++; $display("FAIL skip_grant: got %b want %b (k=%0d)", req_ready, oh(g[k]), k); end
            push(g[k], a[g[k]*W +: W], b[g[k]*W +: W]);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        logic [N*W-1:0] a, b;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a = N*W'($urandom);
            b = N*W'($urandom);
            step(4'b0111, a, b);
            n_chk++; if (req_ready !== oh(k)) begin n_fail++; $display("FAIL mid_grant: got %b want %b", req_ready, oh(k)); end
        end
        step('0, '0, '0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        sb.delete();
        @(negedge clk);
        n_chk++; if (resp_valid !== '0) begin n_fail++; $display("FAIL mid_resp_in_reset: got %b want 0", resp_valid); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        a = '0; b = '0;
        a[0 +: W] = 8'd17;
        b[0 +: W] = 8'd9;
        req_valid = 4'b0001;
        req_a = a;
        req_b = b;
        @(negedge clk);
        n_chk++; if (inflight !== '0) begin n_fail++; $display("FAIL mid_inflight: got %0d want 0", inflight); end
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
        push(0, 8'd17, 8'd9);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] a, b;
        for (int k = 0; k < 20; k++) begin
            a = N*W'($urandom);
            b = N*W'($urandom);
            step(4'b1000, a, b);
            n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL b2b_grant: got %b want 1000 (k=%0d)", req_ready, k); end
            push(3, a[3*W +: W], b[3*W +: W]);
            if (k >= 6) begin
                n_chk++; if (inflight !== CW'(PD)) begin n_fail++; $display("FAIL b2b_inflight: got %0d want %0d (k=%0d)", inflight, PD, k); end
            end
        end
        drain();
        n_chk++; if (inflight !== '0 || idle !== 1'b1) begin n_fail++; $display("FAIL b2b_final: got inflight=%0d idle=%b want 0/1", inflight, idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_width();
        test_ptr_skip();
        test_reset_midflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, want completion");
        $fatal(1, "timeout");
    end

endmodule
